shift_req_arbiter: RTL
======================

// Module: shift_req_arbiter
// PURPOSE
//   Shares one fixed-latency shift datapath (result = operand << 5, 32-bit) between
//   NUM_REQ requesters. Round-robin arbitration, one operation in flight at a time.
//   Each result returns on a single response channel tagged with the requester id.
//   Counts completed operations. Sits between the requesting units and the shift unit.
// PARAMETERS
//   NUM_REQ   4   number of requesters (2..8)
//   DATA_W    32  operand/result width
//   ID_W      2   requester id width, = clog2(NUM_REQ)
//   SHIFT_LAT 1   cycles from shStart high to shResult valid (1..4)
// PORTS
//   clk        in   1               rising-edge clock
//   resetN     in   1               synchronous reset, active low
//   reqValid   in   NUM_REQ         per-requester request valid
//   reqData    in   NUM_REQ*DATA_W  operands; requester i at [i*DATA_W +: DATA_W]
//   reqReady   out  NUM_REQ         one-hot grant; accept = reqValid[i] & reqReady[i]
//   shOperand  out  DATA_W          operand driven to shift datapath
//   shStart    out  1               one-cycle start pulse to datapath
//   shResult   in   DATA_W          datapath result, valid SHIFT_LAT cycles after shStart
//   respValid  out  1               response valid
//   respId     out  ID_W            requester id of response
//   respData   out  DATA_W          shifted result
//   respReady  in   1               consumer accepts response when respValid & respReady
//   opCount    out  32              number of completed (accepted) responses
// BEHAVIOUR
//   Reset (resetN low at a clk edge): state=IDLE, rrPtr=0, reqReady=0, shStart=0,
//     shOperand=0, respValid=0, respId=0, respData=0, opCount=0. Mid-op reset aborts;
//     the in-flight op is dropped, no response is produced, and opCount does not change.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: reqReady is combinational. It is one-hot on the first i with reqValid[i]=1,
//     searching from rrPtr upward mod NUM_REQ. It is all-zero if no request, and
//     all-zero outside IDLE.
//     On accept: latch operand and id; rrPtr <= (id+1) mod NUM_REQ; go to ISSUE.
//   ISSUE (1 cycle): shStart=1, shOperand=latched operand; go to WAIT with counter=SHIFT_LAT.
//   WAIT: decrement counter; on the cycle it reaches 0, capture shResult into respData
//     and go to RESP. shOperand holds its value until the next ISSUE.
//   RESP: respValid=1; respId/respData are stable while respValid & !respReady.
//     On respReady: respValid falls next cycle, opCount += 1, go to IDLE.
//   Latency: accept at edge T -> shStart high in cycle T+1 -> respValid high
//     from cycle T+2+SHIFT_LAT. Minimum request-to-request spacing is 3+SHIFT_LAT cycles.
//   Simultaneous requests: exactly one is granted. Losers keep reqValid high and are
//     served in rotation; no requester waits more than NUM_REQ grants.
//   rrPtr wraps NUM_REQ-1 -> 0. opCount wraps 0xFFFFFFFF -> 0 without a flag.
//   Requester deasserting reqValid before grant: legal, no side effects.
//   reqValid/reqData changes outside IDLE are ignored. respReady outside RESP is ignored.
//   Datapath assumption: shResult is a pure function of shOperand, observed only at capture.
// TESTING
//   T1 single: reqValid=0001, reqData[0]=0x00000111 -> one grant to req0; shStart once;
//      respValid=1, respId=0, respData=0x00002220 at cycle T+3; opCount=1.
//   T2 all four valid at once, operands 0x1,0x2,0x3,0x4, respReady=1 -> grant order 0,1,2,3;
//      responses 0x20,0x40,0x60,0x80 with ids 0..3; opCount=4.
//   T3 rotation: after a grant to req2, reqValid=1111 -> next grant is req3, then req0.
//   T4 backpressure: hold respReady=0 for 10 cycles in RESP -> respValid/respId/respData
//      stable; reqReady=0 throughout; after release, opCount increments exactly once.
//   T5 reset mid-op: assert resetN=0 during WAIT -> next cycle all outputs at reset values;
//      no respValid; opCount=0; a new request afterwards is granted to req0 (rrPtr=0).
//   T6 sweep: operand stepped by 0x111 from 0 to 0x0FFFFFFF on random requesters, with
//      random respReady -> every respData == operand << 5 (mod 2^32); opCount = number sent.

Source files
------------

// File: rtl/shift_req_arbiter.sv
// shift_req_arbiter: shares one fixed-latency shift datapath between NUM_REQ
// requesters. Round-robin grant, a single operation in flight, results
// returned on one response channel tagged with the requester id, and a
// running count of completed operations.
module shift_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 2,
  parameter int SHIFT_LAT = 1
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic [DATA_W-1:0]         shOperand,
  output logic                      shStart,
  input  logic [DATA_W-1:0]         shResult,
  output logic                      respValid,
  output logic [ID_W-1:0]           respId,
  output logic [DATA_W-1:0]         respData,
  input  logic                      respReady,
  output logic [31:0]               opCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic [ID_W:0]     idx;
  logic [DATA_W-1:0] gnt_data;
  logic [2:0]        lat_cnt;
  logic              accept;
  logic              capture;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!grant_any && reqValid[idx[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = idx[ID_W-1:0];
      end
    end
  end

  // Operand of the winning requester.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) gnt_data = reqData[k*DATA_W +: DATA_W];
    end
  end

  // A grant is only honoured while idle and out of reset; the counter hitting
  // one in WAIT marks the cycle in which shResult is valid.
  assign accept  = (state == IDLE) && grant_any && resetN;
  assign capture = (state == WAIT) && (lat_cnt == 3'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = RESP;
      RESP:    if (respReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the grant is gated by reset so no requester
  // believes it was accepted on an edge that the reset discards.
  always_comb begin
    reqReady  = '0;
    shStart   = 1'b0;
    respValid = 1'b0;
    case (state)
      IDLE:    if (resetN && grant_any) reqReady[grant_id] = 1'b1;
      ISSUE:   shStart = 1'b1;
      RESP:    respValid = 1'b1;
      default: ;
    endcase
  end

  // Latch the accepted operand/id and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      shOperand <= '0;
      cur_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      shOperand <= gnt_data;
      cur_id    <= grant_id;
      rr_ptr    <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Latency counter: loaded while the start pulse is out, counted down in WAIT.
  always_ff @(posedge clk) begin
    if (!resetN)               lat_cnt <= '0;
    else if (state == ISSUE)   lat_cnt <= 3'(SHIFT_LAT);
    else if (state == WAIT)    lat_cnt <= lat_cnt - 3'd1;
  end

  // Response holding register; stays put until the next capture.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      respData <= '0;
      respId   <= '0;
    end else if (capture) begin
      respData <= shResult;
      respId   <= cur_id;
    end
  end

  // Completed-operation counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (!resetN)                           opCount <= '0;
    else if ((state == RESP) && respReady) opCount <= opCount + 32'd1;
  end

endmodule
